// File: rtl/inner_product_engine.sv
// inner_product_engine: broadcasts one operand per beat to NUM_PE multiply-accumulate lanes
// and emits one rescaled, saturated (optionally ReLU'd) packed word per output group.
module inner_product_engine #(
    parameter int NUM_PE    = 4,
    parameter int OP_WIDTH  = 16,
    parameter int ACC_WIDTH = 48,
    parameter int FRAC_BITS = 0,
    parameter int LEN_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic [LEN_WIDTH-1:0]         cfg_groups,
    input  logic                         cfg_relu,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_WIDTH-1:0]          in_data,
    input  logic [NUM_PE*OP_WIDTH-1:0]   in_weight,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_PE*OP_WIDTH-1:0]   out_data,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-OP_WIDTH+1){1'b0}}, {(OP_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-OP_WIDTH+1){1'b1}}, {(OP_WIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [LEN_WIDTH-1:0]          len_q, len_d, groups_q, groups_d;
    logic [LEN_WIDTH-1:0]          beat_q, beat_d, group_q, group_d;
    logic                          relu_q, relu_d, drain_q, drain_d;
    logic                          cfg_ready_q, cfg_ready_d, in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d, done_q, done_d;
    logic [NUM_PE*OP_WIDTH-1:0]    out_data_q, out_data_d;
    logic                          p_valid_q, p_valid_d, p_first_q, p_first_d;
    logic signed [2*OP_WIDTH-1:0]  prod_q [NUM_PE];
    logic signed [2*OP_WIDTH-1:0]  prod_d [NUM_PE];
    logic signed [ACC_WIDTH-1:0]   acc_q [NUM_PE];
    logic signed [ACC_WIDTH-1:0]   acc_d [NUM_PE];
    logic                          beat_fire, out_fire, last_beat, last_group;

    assign cfg_ready  = cfg_ready_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = done_q;
    assign beat_fire  = in_valid && in_ready_q;
    assign out_fire   = out_valid_q && out_ready;
    assign last_beat  = beat_q == len_q;
    assign last_group = group_q == groups_q;

    function automatic logic [OP_WIDTH-1:0] rescale(input logic signed [ACC_WIDTH-1:0] a, input logic relu);
        logic signed [ACC_WIDTH-1:0] r;
        r = a >>> FRAC_BITS;
        return (relu && r[ACC_WIDTH-1]) ? '0 :
               (r > SAT_MAX) ? SAT_MAX[OP_WIDTH-1:0] :
               (r < SAT_MIN) ? SAT_MIN[OP_WIDTH-1:0] : r[OP_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        groups_d   = groups_q;
        relu_d     = relu_q;
        beat_d     = beat_q;
        group_d    = group_q;
        drain_d    = 1'b0;
        done_d     = 1'b0;
        out_data_d = out_data_q;
        if (state_q == IDLE && cfg_valid) begin
            state_d  = ACCUM;
            len_d    = cfg_len;
            groups_d = cfg_groups;
            relu_d   = cfg_relu;
            beat_d   = '0;
            group_d  = '0;
        end
        if (state_q == ACCUM && beat_fire) begin
            beat_d  = last_beat ? '0 : beat_q + LEN_WIDTH'(1);
            state_d = last_beat ? DRAIN : ACCUM;
        end
        // The accumulator settles one cycle into DRAIN, so the second DRAIN cycle captures it.
        if (state_q == DRAIN) begin
            drain_d = !drain_q;
            state_d = drain_q ? OUTPUT : DRAIN;
            for (int i = 0; i < NUM_PE; i++)
                out_data_d[i*OP_WIDTH +: OP_WIDTH] = drain_q ? rescale(acc_q[i], relu_q) : out_data_q[i*OP_WIDTH +: OP_WIDTH];
        end
        if (state_q == OUTPUT && out_fire) begin
            done_d  = last_group;
            state_d = last_group ? IDLE : ACCUM;
            group_d = group_q + LEN_WIDTH'(1);
        end
        cfg_ready_d = state_d == IDLE;
        in_ready_d  = state_d == ACCUM;
        out_valid_d = state_d == OUTPUT;
        p_valid_d   = beat_fire;
        p_first_d   = beat_fire ? beat_q == '0 : p_first_q;
        for (int i = 0; i < NUM_PE; i++) begin
            prod_d[i] = beat_fire ? (2*OP_WIDTH)'($signed(in_data)) * (2*OP_WIDTH)'($signed(in_weight[i*OP_WIDTH +: OP_WIDTH])) : prod_q[i];
            acc_d[i]  = !p_valid_q ? acc_q[i] :
                        p_first_q  ? ACC_WIDTH'(prod_q[i]) : acc_q[i] + ACC_WIDTH'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            groups_q    <= '0;
            relu_q      <= 1'b0;
            beat_q      <= '0;
            group_q     <= '0;
            drain_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            groups_q    <= groups_d;
            relu_q      <= relu_d;
            beat_q      <= beat_d;
            group_q     <= group_d;
            drain_q     <= drain_d;
            cfg_ready_q <= cfg_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            for (int i = 0; i < NUM_PE; i++) begin
                prod_q[i] <= prod_d[i];
                acc_q[i]  <= acc_d[i];
            end
        end
    end

endmodule
